// File: rtl/ervp_memory_fifo_ctrl_1r1w.sv
// Valid/ready FIFO controller around an external 1R1W memory with a registered read port.
// Read prefetch plus a 2-entry skid buffer hide the 1-cycle read latency.
module ervp_memory_fifo_ctrl_1r1w #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 32,
  parameter int BW_INDEX = 4,
  parameter int BW_COUNT = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [WIDTH-1:0]    push_data,
  output logic                pop_valid,
  input  logic                pop_ready,
  output logic [WIDTH-1:0]    pop_data,
  output logic [BW_COUNT-1:0] count,
  output logic [BW_INDEX-1:0] mem_windex,
  output logic                mem_wenable,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic [BW_INDEX-1:0] mem_rindex,
  output logic                mem_renable,
  input  logic [WIDTH-1:0]    mem_rdata_synch
);

  localparam logic [BW_INDEX:0] MEM_FULL = (BW_INDEX+1)'(DEPTH);

  logic [BW_INDEX-1:0] wptr_reg, rptr_reg;
  logic [BW_INDEX:0]   mem_cnt_reg;
  logic                inflight_reg;
  logic [1:0]          skid_cnt_reg;
  logic [WIDTH-1:0]    skid0_reg, skid1_reg;

  logic       push_fire, pop_fire;
  logic [1:0] skid_after_pop;
  logic [2:0] occ_after_pop;

  assign push_ready = !rst && !flush && (mem_cnt_reg < MEM_FULL);
  assign push_fire  = push_valid && push_ready;
  assign pop_valid  = (skid_cnt_reg != 2'd0);
  assign pop_fire   = pop_valid && pop_ready;
  assign pop_data   = skid0_reg;

  // Skid occupancy after this cycle's pop, including the read already in flight.
  assign skid_after_pop = skid_cnt_reg - {1'b0, pop_fire};
  assign occ_after_pop  = {1'b0, skid_after_pop} + {2'b00, inflight_reg};
  assign mem_renable    = (mem_cnt_reg != '0) && (occ_after_pop < 3'd2) && !flush && !rst;

  assign mem_windex  = wptr_reg;
  assign mem_wenable = push_fire;
  assign mem_wdata   = push_data;
  assign mem_rindex  = rptr_reg;

  assign count = BW_COUNT'(mem_cnt_reg) + BW_COUNT'(inflight_reg) + BW_COUNT'(skid_cnt_reg);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      mem_cnt_reg  <= '0;
      inflight_reg <= 1'b0;
      skid_cnt_reg <= 2'd0;
    end else begin
      if (push_fire)   wptr_reg <= wptr_reg + BW_INDEX'(1);
      if (mem_renable) rptr_reg <= rptr_reg + BW_INDEX'(1);
      mem_cnt_reg  <= mem_cnt_reg + (BW_INDEX+1)'(push_fire) - (BW_INDEX+1)'(mem_renable);
      inflight_reg <= mem_renable;
      skid_cnt_reg <= skid_after_pop + {1'b0, inflight_reg};
    end
  end

  // Returning data lands in the first slot left free after a same-cycle shift.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      skid0_reg <= '0;
      skid1_reg <= '0;
    end else begin
      if (inflight_reg && skid_after_pop == 2'd0) skid0_reg <= mem_rdata_synch;
      else if (pop_fire)                          skid0_reg <= skid1_reg;
      if (inflight_reg && skid_after_pop == 2'd1) skid1_reg <= mem_rdata_synch;
    end
  end

  a_skid_bound: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, skid_cnt_reg} + {2'b00, inflight_reg}) <= 3'd2);
  a_no_return_when_full: assert property (@(posedge clk) disable iff (rst)
    !(inflight_reg && skid_cnt_reg == 2'd2));

endmodule

// File: tb/tb_ervp_memory_fifo_ctrl_1r1w.sv
// Scoreboard bench for ervp_memory_fifo_ctrl_1r1w with a behavioural memory and queue model.
module tb_ervp_memory_fifo_ctrl_1r1w;
  localparam int DEPTH = 4, WIDTH = 8, BW_INDEX = 2, BW_COUNT = 4;

  logic clk = 0, rst = 1, flush = 0, push_valid = 0, pop_ready = 0;
  logic [WIDTH-1:0]    push_data = '0;
  logic                push_ready, pop_valid, mem_wenable, mem_renable;
  logic [WIDTH-1:0]    pop_data, mem_wdata, mem_rdata_synch;
  logic [BW_COUNT-1:0] count;
  logic [BW_INDEX-1:0] mem_windex, mem_rindex;

  int checks = 0, errors = 0, pop_total = 0;
  bit mon_en = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] mem_model [DEPTH];

  ervp_memory_fifo_ctrl_1r1w #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BW_INDEX(BW_INDEX), .BW_COUNT(BW_COUNT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count),
    .mem_windex(mem_windex), .mem_wenable(mem_wenable), .mem_wdata(mem_wdata),
    .mem_rindex(mem_rindex), .mem_renable(mem_renable), .mem_rdata_synch(mem_rdata_synch)
  );

  always #5 clk = ~clk;

  // External memory cell: write array, registered read port.
  always @(posedge clk) begin
    if (mem_wenable) mem_model[mem_windex] <= mem_wdata;
    if (mem_renable) mem_rdata_synch <= mem_model[mem_rindex];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy against the queue model, popped words against queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count_vs_model", 32'(count), q.size());
      if (pop_valid && pop_ready && !rst && !flush) begin
        pop_total++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_empty: got 0x%0h expected no word at %0t", pop_data, $time);
        end else begin
          logic [WIDTH-1:0] exp;
          exp = q.pop_front();
          check("pop_data", 32'(pop_data), 32'(exp));
          $display("pop  0x%02h (expected 0x%02h)", pop_data, exp);
        end
      end
      if (push_valid && push_ready) begin
        q.push_back(push_data);
        $display("push 0x%02h", push_data);
      end
      if (rst || flush) q.delete();
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    push_valid = 0; pop_ready = 1;
    while (count != 0 && n < 100) begin step(); n++; end
    check("drain_done", 32'(count), 0);
    pop_ready = 0;
  endtask

  task automatic push_burst(input logic [WIDTH-1:0] base, input int n, input string name);
    pop_ready = 0;
    for (int i = 0; i < n; i++) begin
      push_valid = 1; push_data = base + WIDTH'(i); #1;
      check(name, 32'(push_ready), 1);
      step();
    end
    push_valid = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, pops, first, last, cyc, stalls, pops_before;
    rst = 1; step(); mon_en = 1; step();
    push_valid = 1; push_data = 8'h99; #1;
    check("rst_push_ready", 32'(push_ready), 0);
    check("rst_wenable", 32'(mem_wenable), 0);
    step(); rst = 0; push_valid = 0; #1;
    check("reset_pop_valid", 32'(pop_valid), 0);
    check("reset_count", 32'(count), 0);
    check("reset_pop_data", 32'(pop_data), 0);
    check("reset_renable", 32'(mem_renable), 0);
    check("reset_push_ready", 32'(push_ready), 1);

    // Latency: push edge E0, read issue E1, skid fill E2.
    pop_ready = 0; push_valid = 1; push_data = 8'h11; #1;
    check("lat_push_ready", 32'(push_ready), 1);
    step();
    check("lat_e0_pop_valid", 32'(pop_valid), 0);
    push_data = 8'h22;
    step(); push_valid = 0;
    check("lat_e1_pop_valid", 32'(pop_valid), 0);
    step();
    check("lat_e2_pop_valid", 32'(pop_valid), 1);
    check("lat_e2_pop_data", 32'(pop_data), 32'h11);
    step(); step();
    check("two_word_count", 32'(count), 2);
    drain();

    // Full: DEPTH in memory plus 2 in skid.
    push_burst(8'hA0, 6, "fill_push_ready");
    push_valid = 1; push_data = 8'hFF;
    step(); step(); step(); #1;
    check("full_push_ready", 32'(push_ready), 0);
    check("full_count", 32'(count), 6);
    drain(); #1;
    check("empty_push_ready", 32'(push_ready), 1);

    // Streaming: once primed, one pop per cycle.
    pushed = 0; pops = 0; first = -1; last = -1; cyc = 0; stalls = 0;
    pop_ready = 1;
    while (pops < 100 && cyc < 400) begin
      push_valid = (pushed < 100); push_data = WIDTH'(pushed); #1;
      if (push_valid && push_ready) pushed++;
      if (push_valid && !push_ready) stalls++;
      if (pop_valid) begin
        if (first < 0) first = cyc;
        last = cyc; pops++;
      end
      step(); cyc++;
    end
    push_valid = 0;
    check("stream_pops", pops, 100);
    check("stream_span", last - first + 1, 100);
    check("stream_push_stalls", stalls, 0);
    drain();

    // Random traffic.
    pushed = 0; cyc = 0;
    while (pushed < 2000 && cyc < 20000) begin
      push_valid = 1'($urandom_range(0, 1));
      push_data  = WIDTH'($urandom);
      pop_ready  = 1'($urandom_range(0, 1));
      #1;
      if (push_valid && push_ready) pushed++;
      step(); cyc++;
    end
    check("rand_pushed", pushed, 2000);
    drain();

    // Flush while a read is in flight.
    push_burst(8'hC0, 5, "flush_fill_ready");
    step(); step(); step(); step();
    check("pre_flush_count", 32'(count), 5);
    pop_ready = 1; #1;
    check("pre_flush_renable", 32'(mem_renable), 1);
    step();
    pop_ready = 0; flush = 1; #1;
    check("flush_push_ready", 32'(push_ready), 0);
    check("flush_renable", 32'(mem_renable), 0);
    step(); flush = 0; #1;
    check("post_flush_count", 32'(count), 0);
    check("post_flush_pop_valid", 32'(pop_valid), 0);
    check("post_flush_pop_data", 32'(pop_data), 0);
    pops_before = pop_total;
    push_valid = 1; push_data = 8'h5A; step(); push_valid = 0;
    pop_ready = 1;
    for (int i = 0; i < 8; i++) step();
    check("flush_new_pops", pop_total - pops_before, 1);
    check("flush_tail_pop_valid", 32'(pop_valid), 0);
    pop_ready = 0;

    // Reset mid-stream.
    push_burst(8'h30, 3, "rst_fill_ready");
    step(); step(); step();
    check("pre_rst_count", 32'(count), 3);
    rst = 1; push_valid = 1; push_data = 8'h77; #1;
    check("mid_rst_push_ready", 32'(push_ready), 0);
    check("mid_rst_wenable", 32'(mem_wenable), 0);
    step(); rst = 0; push_valid = 0; #1;
    check("post_rst_pop_valid", 32'(pop_valid), 0);
    check("post_rst_count", 32'(count), 0);
    check("post_rst_pop_data", 32'(pop_data), 0);
    check("post_rst_wenable", 32'(mem_wenable), 0);
    check("post_rst_renable", 32'(mem_renable), 0);
    check("post_rst_push_ready", 32'(push_ready), 1);
    push_burst(8'h3C, 1, "post_rst_push");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
